// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flip-flop, LSB first.
// Optional feature macro: SERIAL_SUB_SAT_EN (clamp a negative result to zero).
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-2:0] sr;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] res_next;

   // Full-subtractor cell; res_next is the collected result including the current bit.
   always_comb begin
      d        = sa[0] ^ sb[0] ^ br;
      br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      res_next = {d, sr};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         sr     <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  sr    <= '0;
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               br  <= br_next;
               sr  <= res_next[WIDTH-1:1];
               sa  <= {1'b0, sa[WIDTH-1:1]};
               sb  <= {1'b0, sb[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
`ifdef SERIAL_SUB_SAT_EN
                  diff <= br_next ? '0 : res_next;
`else
                  diff <= res_next;
`endif
                  borrow <= br_next;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
